// File: rtl/prf_wb_arbiter.sv
// rtl/prf_wb_arbiter.sv - round-robin arbiter sharing N PRF write ports among NUM_REQ result sources
module prf_wb_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int N       = 3,
    parameter int PRN_W   = 6,
    parameter int DATA    = 32
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*PRN_W-1:0]    req_prn,
    input  logic [NUM_REQ*DATA-1:0]     req_value,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [N*(DATA+PRN_W)-1:0]   write_data,
    output logic [NUM_REQ-1:0]          grant
);

    localparam int WR_W  = DATA + PRN_W;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // One-entry holding buffer per source
    logic [NUM_REQ-1:0] buf_valid;
    logic [PRN_W-1:0]   buf_prn   [NUM_REQ];
    logic [DATA-1:0]    buf_value [NUM_REQ];

    // Round-robin start point: one past the last index granted
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_nxt;

    logic               dup_prn;

    // Scan from rr_ptr, granting the first N valid buffers; grant k drives slot k.
    // Only registered state feeds this, so req_* never reaches write_data or grant.
    always_comb begin
        int cnt;
        int idx;
        grant      = '0;
        write_data = '0;
        rr_ptr_nxt = rr_ptr;
        cnt        = 0;
        idx        = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = (int'(rr_ptr) + j) % NUM_REQ;
            if (buf_valid[idx] && (cnt < N)) begin
                grant[idx] = 1'b1;
                write_data[cnt*WR_W +: WR_W] = {buf_value[idx], buf_prn[idx]};
                rr_ptr_nxt = PTR_W'((idx + 1) % NUM_REQ);
                cnt++;
            end
        end
    end

    // A source may refill in the same cycle its buffer drains; nothing is accepted during a flush
    always_comb begin
        req_ready = '0;
        if (!flush) begin
            req_ready = ~buf_valid | grant;
        end
    end

    // Buffer capture/drain and pointer advance; flush squashes buffers but not the pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_prn[i]   <= '0;
                buf_value[i] <= '0;
            end
        end else begin
            rr_ptr <= rr_ptr_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush) begin
                    buf_valid[i] <= 1'b0;
                end else if (req_valid[i] && req_ready[i]) begin
                    // A prn==0 result has no destination: accept it but never occupy a port
                    buf_valid[i] <= (req_prn[i*PRN_W +: PRN_W] != '0);
                    buf_prn[i]   <= req_prn[i*PRN_W +: PRN_W];
                    buf_value[i] <= req_value[i*DATA +: DATA];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Detect two valid buffers targeting the same physical register (an upstream bug)
    always_comb begin
        dup_prn = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = i + 1; j < NUM_REQ; j++) begin
                if (buf_valid[i] && buf_valid[j] && (buf_prn[i] == buf_prn[j])) begin
                    dup_prn = 1'b1;
                end
            end
        end
    end

    no_dup_prn: assert property (@(posedge clock) disable iff (!reset_n) !dup_prn);

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// tb/tb_prf_wb_arbiter.sv - directed self-checking bench for prf_wb_arbiter
module tb_prf_wb_arbiter;

    localparam int NUM_REQ = 8;
    localparam int N       = 3;
    localparam int PRN_W   = 6;
    localparam int DATA    = 32;
    localparam int WR_W    = DATA + PRN_W;

    logic                      clock;
    logic                      reset_n;
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PRN_W-1:0]  req_prn;
    logic [NUM_REQ*DATA-1:0]   req_value;
    logic [NUM_REQ-1:0]        req_ready;
    logic [N*WR_W-1:0]         write_data;
    logic [NUM_REQ-1:0]        grant;

    int checks   = 0;
    int failures = 0;

    prf_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .N       (N),
        .PRN_W   (PRN_W),
        .DATA    (DATA)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_prn    (req_prn),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .write_data (write_data),
        .grant      (grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PRN_W-1:0] slot_prn(input int k);
        return write_data[k*WR_W +: PRN_W];
    endfunction

    function automatic logic [DATA-1:0] slot_val(input int k);
        return write_data[k*WR_W+PRN_W +: DATA];
    endfunction

    task automatic set_req(input int src, input logic [PRN_W-1:0] prn, input logic [DATA-1:0] val);
        req_prn[src*PRN_W +: PRN_W] = prn;
        req_value[src*DATA +: DATA] = val;
    endtask

    // Inputs change 2 time units after the edge; outputs are sampled 1 unit later
    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    initial begin
        logic [NUM_REQ-1:0] hist [3];
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_prn   = '0;
        req_value = '0;
        #2;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_wd_zero", 64'(write_data == '0), 64'h1);
        @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            chk("idle_wd_zero", 64'(write_data == '0), 64'h1);
            chk("idle_grant", 64'(grant), 64'h0);
            chk("idle_ready", 64'(req_ready), 64'hFF);
        end

        // All 8 sources in one cycle, prn 1..8
        next_cycle();
        req_valid = 8'hFF;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, PRN_W'(i + 1), DATA'(100 + i));
        #1;
        chk("all_ready", 64'(req_ready), 64'hFF);
        chk("all_rr0", 64'(dut.rr_ptr), 64'd0);
        next_cycle();
        req_valid = '0;
        #1;
        chk("all_c1_grant", 64'(grant), 64'h07);
        chk("all_c1_p0", 64'(slot_prn(0)), 64'd1);
        chk("all_c1_p1", 64'(slot_prn(1)), 64'd2);
        chk("all_c1_p2", 64'(slot_prn(2)), 64'd3);
        chk("all_c1_v0", 64'(slot_val(0)), 64'd100);
        chk("all_c1_v2", 64'(slot_val(2)), 64'd102);
        chk("all_c1_ready", 64'(req_ready), 64'h07);
        next_cycle();
        #1;
        chk("all_c2_rr", 64'(dut.rr_ptr), 64'd3);
        chk("all_c2_grant", 64'(grant), 64'h38);
        chk("all_c2_p0", 64'(slot_prn(0)), 64'd4);
        chk("all_c2_p1", 64'(slot_prn(1)), 64'd5);
        chk("all_c2_p2", 64'(slot_prn(2)), 64'd6);
        next_cycle();
        #1;
        chk("all_c3_rr", 64'(dut.rr_ptr), 64'd6);
        chk("all_c3_grant", 64'(grant), 64'hC0);
        chk("all_c3_p0", 64'(slot_prn(0)), 64'd7);
        chk("all_c3_p1", 64'(slot_prn(1)), 64'd8);
        chk("all_c3_p2", 64'(slot_prn(2)), 64'd0);
        chk("all_c3_v2", 64'(slot_val(2)), 64'd0);
        next_cycle();
        #1;
        chk("all_c4_rr", 64'(dut.rr_ptr), 64'd0);
        chk("all_c4_grant", 64'(grant), 64'h0);

        // Source 5 streaming prn 10, 11, 12
        req_prn   = '0;
        req_value = '0;
        next_cycle();
        req_valid = 8'h20;
        set_req(5, 6'd10, 32'hA);
        #1;
        chk("str_ready_a", 64'(req_ready[5]), 64'h1);
        next_cycle();
        set_req(5, 6'd11, 32'hB);
        #1;
        chk("str_grant_b", 64'(grant), 64'h20);
        chk("str_p_b", 64'(slot_prn(0)), 64'd10);
        chk("str_ready_b", 64'(req_ready[5]), 64'h1);
        next_cycle();
        set_req(5, 6'd12, 32'hC);
        #1;
        chk("str_p_c", 64'(slot_prn(0)), 64'd11);
        chk("str_v_c", 64'(slot_val(0)), 64'hB);
        chk("str_ready_c", 64'(req_ready[5]), 64'h1);
        next_cycle();
        req_valid = '0;
        #1;
        chk("str_p_d", 64'(slot_prn(0)), 64'd12);
        chk("str_grant_d", 64'(grant), 64'h20);
        next_cycle();
        #1;
        chk("str_idle_grant", 64'(grant), 64'h0);
        chk("str_rr", 64'(dut.rr_ptr), 64'd6);

        // prn==0 request from source 2 is accepted and dropped
        next_cycle();
        req_valid = 8'h04;
        set_req(2, 6'd0, 32'hDEAD);
        #1;
        chk("p0_ready", 64'(req_ready[2]), 64'h1);
        next_cycle();
        req_valid = '0;
        #1;
        chk("p0_grant", 64'(grant), 64'h0);
        chk("p0_wd_zero", 64'(write_data == '0), 64'h1);
        chk("p0_bufv", 64'(dut.buf_valid[2]), 64'h0);

        // All sources continuously valid; rr_ptr starts at 6
        next_cycle();
        req_valid = 8'hFF;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, PRN_W'(i + 1), DATA'(200 + i));
        #1;
        chk("stv_s0_grant", 64'(grant), 64'h0);
        for (int s = 1; s <= 9; s++) begin
            next_cycle();
            #1;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = grant;
            chk("stv_count3", 64'($countones(grant)), 64'd3);
            if (s == 1) chk("stv_s1_grant", 64'(grant), 64'hC1);
            if (s == 2) chk("stv_s2_grant", 64'(grant), 64'h0E);
            if (s >= 3) chk("stv_window", 64'(hist[0] | hist[1] | hist[2]), 64'hFF);
        end

        // Asynchronous reset mid-cycle with all buffers full
        next_cycle();
        #1;
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        chk("arst_grant", 64'(grant), 64'h0);
        chk("arst_wd_zero", 64'(write_data == '0), 64'h1);
        chk("arst_bufv", 64'(dut.buf_valid), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Flush with 4 buffered entries, rr_ptr = 0
        req_prn   = '0;
        req_value = '0;
        next_cycle();
        req_valid = 8'h0F;
        for (int i = 0; i < 4; i++) set_req(i, PRN_W'(20 + i), DATA'(300 + i));
        #1;
        chk("fl_load_ready", 64'(req_ready), 64'hFF);
        next_cycle();
        flush     = 1'b1;
        req_valid = 8'h10;
        set_req(4, 6'd30, 32'd400);
        #1;
        chk("fl_grant", 64'(grant), 64'h07);
        chk("fl_p0", 64'(slot_prn(0)), 64'd20);
        chk("fl_p1", 64'(slot_prn(1)), 64'd21);
        chk("fl_p2", 64'(slot_prn(2)), 64'd22);
        chk("fl_v1", 64'(slot_val(1)), 64'd301);
        chk("fl_ready", 64'(req_ready), 64'h00);
        next_cycle();
        flush     = 1'b0;
        req_valid = '0;
        #1;
        chk("fl_after_grant", 64'(grant), 64'h0);
        chk("fl_after_wd_zero", 64'(write_data == '0), 64'h1);
        chk("fl_after_bufv", 64'(dut.buf_valid), 64'h0);
        chk("fl_after_rr", 64'(dut.rr_ptr), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
